// File: rtl/detector_notas.sv
`default_nettype none
// ============================================================================
// Module      : detector_notas
// Description : Measures half-periods of an incoming square wave and reports
//               which of eight musical notes it matches once stable.
// Revision    : 1.0 - initial release
// ============================================================================
module detector_notas #(
    parameter int CLOCK   = 50000000,
    parameter int P_DO    = 373,
    parameter int P_RE    = 333,
    parameter int P_MI    = 296,
    parameter int P_FA    = 280,
    parameter int P_SOL   = 249,
    parameter int P_LA    = 222,
    parameter int P_SI    = 198,
    parameter int P_DO5   = 187,
    parameter int TOL     = 4,
    parameter int CONFIRM = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sinal_in,
    output logic [7:0] notas,
    output logic       valida,
    output logic [9:0] periodo
);

    localparam int c_CW = $clog2(CONFIRM + 1);
    localparam logic [c_CW-1:0] c_CONFIRM = c_CW'(CONFIRM);
    localparam logic [9:0] c_TMO = 10'(TIMEOUT);
    localparam int c_P [8] = '{P_DO, P_RE, P_MI, P_FA, P_SOL, P_LA, P_SI, P_DO5};

    generate
        if (CLOCK < 1) begin : g_clock_check
            $error("detector_notas: CLOCK must be positive");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEDINDO = 2'd1,
        S_TRAVADO = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_hist;
    logic [1:0]      r_arm;
    logic [9:0]      r_cnt;
    logic [2:0]      r_cand;
    logic            r_cand_v;
    logic [c_CW-1:0] r_mcnt;

    logic            w_edge;
    logic            w_hit;
    logic [2:0]      w_idx;
    logic [2:0]      w_cand;
    logic            w_cand_v;
    logic [c_CW-1:0] w_mcnt;
    logic            w_lock;

    // Strobes are masked until the synchronizer has refilled after reset,
    // so a high input at release cannot look like an edge.
    assign w_edge = (r_sync2 ^ r_hist) & (r_arm == 2'd3);

    // Descending scan so the lowest matching note index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (((int'(r_cnt) - c_P[k]) <= TOL) && ((c_P[k] - int'(r_cnt)) <= TOL)) begin
                w_hit = 1'b1;
                w_idx = 3'(k);
            end
        end
    end

    always_comb begin
        w_cand   = 3'd0;
        w_cand_v = 1'b0;
        w_mcnt   = '0;
        if (w_hit && r_cand_v && (w_idx == r_cand)) begin
            w_cand   = r_cand;
            w_cand_v = 1'b1;
            w_mcnt   = (r_mcnt >= c_CONFIRM) ? c_CONFIRM : r_mcnt + c_CW'(1);
        end else if (w_hit) begin
            w_cand   = w_idx;
            w_cand_v = 1'b1;
            w_mcnt   = c_CW'(1);
        end
    end

    assign w_lock = (w_mcnt == c_CONFIRM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= 1'b0;
            r_arm    <= 2'd0;
            r_cnt    <= 10'd0;
            r_cand   <= 3'd0;
            r_cand_v <= 1'b0;
            r_mcnt   <= '0;
            notas    <= 8'd0;
            valida   <= 1'b0;
            periodo  <= 10'd0;
        end else begin
            r_sync1 <= sinal_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end

            // Loading 1 on a strobe makes the next strobe read exactly N.
            if (w_edge) begin
                r_cnt <= 10'd1;
            end else if (r_cnt != 10'd1023) begin
                r_cnt <= r_cnt + 10'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state  <= S_MEDINDO;
                        r_cand   <= 3'd0;
                        r_cand_v <= 1'b0;
                        r_mcnt   <= '0;
                    end
                end
                default: begin
                    if (w_edge) begin
                        periodo  <= r_cnt;
                        r_cand   <= w_cand;
                        r_cand_v <= w_cand_v;
                        r_mcnt   <= w_mcnt;
                        if (w_lock) begin
                            r_state <= S_TRAVADO;
                            notas   <= 8'd1 << w_cand;
                            valida  <= 1'b1;
                        end else begin
                            r_state <= S_MEDINDO;
                            notas   <= 8'd0;
                            valida  <= 1'b0;
                        end
                    end else if (r_cnt == c_TMO) begin
                        r_state  <= S_IDLE;
                        r_cand   <= 3'd0;
                        r_cand_v <= 1'b0;
                        r_mcnt   <= '0;
                        notas    <= 8'd0;
                        valida   <= 1'b0;
                        periodo  <= 10'd0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_detector_notas.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_notas
// Description : Directed, table-driven self-checking bench for detector_notas.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_notas;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       sinal_in = 1'b0;
    logic [7:0] notas;
    logic       valida;
    logic [9:0] periodo;

    int n_tests   = 0;
    int n_fail    = 0;
    int gen_half  = 0;
    int gen_cnt   = 0;
    int n_toggles = 0;

    typedef struct {
        int         half;
        int         toggles;
        logic [7:0] exp_notas;
        logic       exp_valida;
        logic [9:0] exp_periodo;
    } vec_t;

    vec_t vecs [15];
    int   ptab [8] = '{373, 333, 296, 280, 249, 222, 198, 187};

    detector_notas dut (
        .clk      (clk),
        .reset    (reset),
        .sinal_in (sinal_in),
        .notas    (notas),
        .valida   (valida),
        .periodo  (periodo)
    );

    initial begin
        forever #10 clk = ~clk;
    end

    // Square-wave source: toggles every gen_half clock edges, idle when 0.
    initial begin
        forever begin
            @(posedge clk);
            if (gen_half == 0) begin
                gen_cnt = 0;
            end else begin
                gen_cnt++;
                if (gen_cnt >= gen_half) begin
                    gen_cnt = 0;
                    #1 sinal_in = ~sinal_in;
                    n_toggles++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] en, input logic ev, input logic [9:0] ep);
        check({name, " notas"}, 32'(notas), 32'(en));
        check({name, " valida"}, 32'(valida), 32'(ev));
        check({name, " periodo"}, 32'(periodo), 32'(ep));
    endtask

    task automatic wait_toggles(input int k);
        int target;
        int budget;
        target = n_toggles + k;
        budget = k * 1100 + 20;
        while ((n_toggles < target) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (n_toggles < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_toggles: got %0d toggles, expected %0d", n_toggles, target);
        end
    endtask

    // A toggle becomes a processed strobe two edges after it is first seen.
    task automatic after_strobe();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gen_half = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{222, 5, 8'h20, 1'b1, 10'd222};
        vecs[1]  = '{222, 4, 8'h00, 1'b0, 10'd222};
        vecs[2]  = '{226, 5, 8'h20, 1'b1, 10'd226};
        vecs[3]  = '{218, 5, 8'h20, 1'b1, 10'd218};
        vecs[4]  = '{227, 6, 8'h00, 1'b0, 10'd227};
        vecs[5]  = '{217, 6, 8'h00, 1'b0, 10'd217};
        vecs[6]  = '{373, 5, 8'h01, 1'b1, 10'd373};
        vecs[7]  = '{377, 5, 8'h01, 1'b1, 10'd377};
        vecs[8]  = '{333, 5, 8'h02, 1'b1, 10'd333};
        vecs[9]  = '{296, 5, 8'h04, 1'b1, 10'd296};
        vecs[10] = '{280, 5, 8'h08, 1'b1, 10'd280};
        vecs[11] = '{249, 5, 8'h10, 1'b1, 10'd249};
        vecs[12] = '{198, 5, 8'h40, 1'b1, 10'd198};
        vecs[13] = '{187, 5, 8'h80, 1'b1, 10'd187};
        vecs[14] = '{285, 6, 8'h00, 1'b0, 10'd285};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_out("reset", 8'h00, 1'b0, 10'd0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            gen_half = vecs[i].half;
            wait_toggles(vecs[i].toggles);
            after_strobe();
            check_out($sformatf("vec%0d half=%0d", i, vecs[i].half),
                      vecs[i].exp_notas, vecs[i].exp_valida, vecs[i].exp_periodo);
        end

        // High input at reset release must not create a spurious first edge.
        do_reset();
        sinal_in = 1'b1;
        do_reset();
        gen_half = 222;
        wait_toggles(4);
        after_strobe();
        check_out("refill 4 edges", 8'h00, 1'b0, 10'd222);
        wait_toggles(1);
        after_strobe();
        check_out("refill 5 edges", 8'h20, 1'b1, 10'd222);

        // Note change from DO to DO5 while locked.
        do_reset();
        gen_half = 373;
        wait_toggles(5);
        gen_half = 187;
        after_strobe();
        check_out("switch locked do", 8'h01, 1'b1, 10'd373);
        wait_toggles(1);
        after_strobe();
        check_out("switch first 187", 8'h00, 1'b0, 10'd187);
        wait_toggles(2);
        after_strobe();
        check_out("switch third 187", 8'h00, 1'b0, 10'd187);
        wait_toggles(1);
        after_strobe();
        check_out("switch fourth 187", 8'h80, 1'b1, 10'd187);

        // Timeout boundary: still locked at 1022 cycles, idle at 1023.
        do_reset();
        gen_half = 249;
        wait_toggles(5);
        gen_half = 0;
        after_strobe();
        check_out("timeout locked", 8'h10, 1'b1, 10'd249);
        repeat (1022) @(posedge clk);
        #1;
        check_out("timeout minus1", 8'h10, 1'b1, 10'd249);
        @(posedge clk);
        #1;
        check_out("timeout fired", 8'h00, 1'b0, 10'd0);

        // Reset pulse mid-lock, then relock on fresh edges only.
        do_reset();
        gen_half = 280;
        wait_toggles(5);
        after_strobe();
        check_out("pulse locked", 8'h08, 1'b1, 10'd280);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_out("pulse cleared", 8'h00, 1'b0, 10'd0);
        wait_toggles(4);
        after_strobe();
        check_out("pulse 4 edges", 8'h00, 1'b0, 10'd280);
        wait_toggles(1);
        after_strobe();
        check_out("pulse 5 edges", 8'h08, 1'b1, 10'd280);

        // Eight-note sweep.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            gen_half = ptab[k];
            for (int t = 0; t < 10; t++) begin
                wait_toggles(1);
                after_strobe();
                check($sformatf("sweep%0d onehot", k), 32'($onehot0(notas)), 32'd1);
                check($sformatf("sweep%0d valida", k), 32'(valida), 32'(|notas));
            end
            check($sformatf("sweep%0d notas", k), 32'(notas), 32'(8'd1 << k));
        end
        gen_half = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/detector_notas.md
DETECTOR_NOTAS -- requirements
Module: detector_notas

Interface
REQ-001 SHALL have parameter CLOCK, default 50000000, system clock frequency in Hz (informational; the period table below is derived from it).
REQ-002 SHALL have parameters P_DO, P_RE, P_MI, P_FA, P_SOL, P_LA, P_SI, P_DO5, defaults 373, 333, 296, 280, 249, 222, 198, 187: nominal half-periods in clk cycles, matching the note generator's toggle intervals.
REQ-003 SHALL have parameter TOL, default 4, the allowed ± deviation in cycles for a half-period match.
REQ-004 SHALL have parameter CONFIRM, default 4, the number of consecutive matching half-periods needed to lock.
REQ-005 SHALL have parameter TIMEOUT, default 1023, the number of cycles without an edge before the detector drops to idle.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port sinal_in, input, 1 bit: square wave under test, asynchronous to clk.
REQ-009 SHALL have port notas, output, 8 bits: one-hot detected note (bit0 = do … bit7 = do5), all zero when nothing is detected.
REQ-010 SHALL have port valida, output, 1 bit: high while locked; equals OR of notas.
REQ-011 SHALL have port periodo, output, 10 bits: last measured half-period in cycles.

Function
REQ-012 SHALL pass sinal_in through a 2-flop synchronizer plus one history flop.
REQ-013 SHALL generate an edge strobe on every cycle where the synchronized value differs from the history flop; both rising and falling edges count.
REQ-014 SHALL define the measured half-period D as the number of clk cycles between consecutive edge strobes; a wave toggling every N cycles yields D = N exactly.
REQ-015 SHALL use a cycle counter that is 10 bits wide, saturating at 1023 and never wrapping.
REQ-016 SHALL load periodo with D on each edge strobe that has a preceding edge; the first edge after IDLE produces no measurement and leaves periodo unchanged.
REQ-017 SHALL consider D a match to note k when |D − P_k| <= TOL; with the defaults at most one note can match, and if several match the lowest index wins.
REQ-018 SHALL implement state machine IDLE, MEDINDO, TRAVADO.
REQ-019 SHALL perform IDLE->MEDINDO on the first edge strobe, with candidate cleared and match count 0.
REQ-020 SHALL handle a measurement in MEDINDO or TRAVADO as follows:
- D matches the current candidate: match count increments, saturating at CONFIRM.
- D matches a different note: candidate <= that note, count <= 1.
- D matches no note: candidate cleared, count <= 0.
REQ-021 SHALL enter TRAVADO when count reaches CONFIRM; notas and valida update on the cycle after the CONFIRM-th matching edge strobe.
REQ-022 SHALL, in TRAVADO, drop notas and valida to 0 on the cycle after any measurement that does not match the locked note, and return to MEDINDO with the REQ-020 candidate/count update applied.
REQ-023 SHALL, on reaching TIMEOUT cycles since the last edge in MEDINDO or TRAVADO, go to IDLE with notas = 0, valida = 0, periodo = 0, and count cleared.
REQ-024 SHALL treat an edge strobe on the same cycle the timeout fires as taking priority: the timeout is ignored and the measurement is 1023, which is no match.
REQ-025 SHALL change outputs only on clk rising edges and never glitch combinationally.

Reset
REQ-026 SHALL, while reset is high at a clk edge, set state = IDLE, notas = 0, valida = 0, periodo = 0, clear counter, candidate, count and synchronizer flops.
REQ-027 SHALL reach the same values when reset is asserted mid-lock, taking effect at the first clk edge where reset is high.
REQ-028 SHALL ignore edges in the 3 cycles after reset release (synchronizer refill), and no false strobe may arise from the cleared flops.

Verification
REQ-029 SHALL cover: square wave toggling every 222 cycles -> after the 5th edge strobe plus 1 cycle, notas = 8'b0010_0000, valida = 1, periodo = 222.
REQ-030 SHALL cover: tolerance edges -> toggle 226 locks LA (notas bit5); toggle 227 never locks, notas = 0, periodo = 227.
REQ-031 SHALL cover: locked on 373 (bit0), then switch to 187 -> first 187 measurement clears valida next cycle; 4th consecutive 187 sets notas = 8'b1000_0000.
REQ-032 SHALL cover: locked on 249, then sinal_in held constant -> 1023 cycles after the last edge, notas = 0, valida = 0, periodo = 0, state IDLE.
REQ-033 SHALL cover: reset pulsed for 1 cycle while locked on 280 -> outputs 0 on the next cycle, and relock requires 5 fresh edges.
REQ-034 SHALL cover: eight-note sweep, driving each P_k for 10 half-periods in turn, with notas following the one-hot index of each note and never two bits set at once.
